// File: rtl/clk_rst_seq.sv
// PLL lock qualifier with staggered per-channel reset release and
// glitch-free, reprogrammable per-channel clock-enable dividers.
module clk_rst_seq #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 8,
  parameter int LOCK_CNT = 1024,
  parameter int STAGGER  = 16
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    locked_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic                    div_upd_i,
  input  logic                    lock_lost_clr_i,
  output logic [NUM_CH-1:0]       rstn_o,
  output logic [NUM_CH-1:0]       clk_en_o,
  output logic                    ready_o,
  output logic                    lock_lost_o
);

  localparam int LCNT_W = $clog2(LOCK_CNT);
  localparam int SCNT_W = $clog2(STAGGER + 1);
  localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCK_CNT - 1);
  localparam logic [SCNT_W-1:0] STAG_LAST = SCNT_W'(STAGGER - 1);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("clk_rst_seq: NUM_CH must be in 1..16");
  end
  if (LOCK_CNT < 2) begin : g_bad_lock_cnt
    $error("clk_rst_seq: LOCK_CNT must be >= 2");
  end
  if (STAGGER < 1) begin : g_bad_stagger
    $error("clk_rst_seq: STAGGER must be >= 1");
  end

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t              r_state;
  logic                r_sync1;
  logic                r_locked_s;
  logic [LCNT_W-1:0]   r_stable_cnt;
  logic [SCNT_W-1:0]   r_stag_cnt;
  logic [NUM_CH-1:0]   r_rstn;
  logic                r_ready;
  logic                r_lock_lost;
  logic [NUM_CH*DIV_W-1:0] r_pend;
  logic [NUM_CH-1:0]   r_pend_v;
  logic [NUM_CH-1:0]   w_load;
  logic                w_drop;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= locked_i;
      r_locked_s <= r_sync1;
    end
  end

  assign w_drop = (r_state == S_RELEASE || r_state == S_RUN) && !r_locked_s;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= S_WAIT_LOCK;
      r_stable_cnt <= '0;
      r_stag_cnt   <= '0;
      r_rstn       <= '0;
      r_ready      <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      if (lock_lost_clr_i) r_lock_lost <= 1'b0;
      case (r_state)
        S_WAIT_LOCK: begin
          r_stable_cnt <= '0;
          if (r_locked_s) r_state <= S_STABLE;
        end
        S_STABLE: begin
          if (!r_locked_s) begin
            r_state      <= S_WAIT_LOCK;
            r_stable_cnt <= '0;
          end else if (r_stable_cnt == LOCK_LAST) begin
            r_state      <= S_RELEASE;
            r_stable_cnt <= '0;
            r_stag_cnt   <= '0;
            r_rstn       <= NUM_CH'(1);
          end else begin
            r_stable_cnt <= r_stable_cnt + LCNT_W'(1);
          end
        end
        S_RELEASE, S_RUN: begin
          // Set is assigned after the clear so a coinciding loss wins.
          if (!r_locked_s) begin
            r_state      <= S_WAIT_LOCK;
            r_rstn       <= '0;
            r_ready      <= 1'b0;
            r_lock_lost  <= 1'b1;
            r_stag_cnt   <= '0;
            r_stable_cnt <= '0;
          end else if (r_state == S_RELEASE) begin
            if (r_stag_cnt == STAG_LAST) begin
              r_stag_cnt <= '0;
              if (r_rstn[NUM_CH-1]) begin
                r_state <= S_RUN;
                r_ready <= 1'b1;
              end else begin
                r_rstn <= r_rstn | (r_rstn << 1);
              end
            end else begin
              r_stag_cnt <= r_stag_cnt + SCNT_W'(1);
            end
          end
        end
        default: r_state <= S_WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pend   <= '0;
      r_pend_v <= '0;
    end else if (div_upd_i) begin
      r_pend   <= div_i;
      r_pend_v <= '1;
    end else begin
      r_pend_v <= r_pend_v & ~w_load;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_en;
    logic             w_hold;
    logic             w_last;

    // New ratios only take effect at a period boundary or while held in reset.
    assign w_hold      = w_drop || !r_rstn[gi];
    assign w_last      = (r_div <= DIV_W'(1)) || (r_cnt == r_div - DIV_W'(1));
    assign w_load[gi]  = r_pend_v[gi] && (w_hold || w_last);
    assign clk_en_o[gi] = r_en;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_div <= DIV_W'(1);
        r_cnt <= '0;
        r_en  <= 1'b0;
      end else begin
        if (w_load[gi]) r_div <= r_pend[gi*DIV_W +: DIV_W];
        if (w_hold) begin
          r_cnt <= '0;
          r_en  <= 1'b0;
        end else begin
          r_en  <= w_last;
          r_cnt <= w_last ? '0 : r_cnt + DIV_W'(1);
        end
      end
    end
  end

  assign rstn_o      = r_rstn;
  assign ready_o     = r_ready;
  assign lock_lost_o = r_lock_lost;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq: release timing, glitchy lock, dividers,
// live ratio update, lock loss/relock and asynchronous reset.
module tb_clk_rst_seq;

  localparam int NUM_CH   = 4;
  localparam int DIV_W    = 8;
  localparam int LOCK_CNT = 16;
  localparam int STAGGER  = 4;

  logic                    clk_i = 1'b0;
  logic                    rstn_i = 1'b1;
  logic                    locked_i = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div_i = '0;
  logic                    div_upd_i = 1'b0;
  logic                    lock_lost_clr_i = 1'b0;
  logic [NUM_CH-1:0]       rstn_o;
  logic [NUM_CH-1:0]       clk_en_o;
  logic                    ready_o;
  logic                    lock_lost_o;

  int n_checks = 0;
  int n_fail   = 0;
  int t_now    = 0;

  always #5 clk_i = ~clk_i;

  clk_rst_seq #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .LOCK_CNT(LOCK_CNT),
    .STAGGER (STAGGER)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .locked_i       (locked_i),
    .div_i          (div_i),
    .div_upd_i      (div_upd_i),
    .lock_lost_clr_i(lock_lost_clr_i),
    .rstn_o         (rstn_o),
    .clk_en_o       (clk_en_o),
    .ready_o        (ready_o),
    .lock_lost_o    (lock_lost_o)
  );

  typedef struct {
    int         off;
    logic [3:0] rstn;
    logic [3:0] en;
    logic       rdy;
  } seq_vec_t;

  seq_vec_t seq_tbl[11];

  task automatic tick();
    @(posedge clk_i);
    #1;
    t_now++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t0+%0d: got 0x%0h, expected 0x%0h", name, t_now, act, exp);
    end
  endtask

  task automatic start_lock();
    locked_i = 1'b1;
    t_now    = -1;
  endtask

  task automatic wait_until(input int off);
    while (t_now < off) tick();
  endtask

  task automatic do_reset();
    rstn_i   = 1'b0;
    locked_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic run_seq(input string tag, input bit chk_en);
    for (int i = 0; i < 11; i++) begin
      wait_until(seq_tbl[i].off);
      $display("%s: t0+%0d rstn_o=%b clk_en_o=%b ready_o=%b", tag, t_now, rstn_o, clk_en_o, ready_o);
      check({tag, "_rstn"}, 32'(rstn_o), 32'(seq_tbl[i].rstn));
      if (chk_en) check({tag, "_clk_en"}, 32'(clk_en_o), 32'(seq_tbl[i].en));
      check({tag, "_ready"}, 32'(ready_o), 32'(seq_tbl[i].rdy));
    end
    check({tag, "_lock_lost"}, 32'(lock_lost_o), 32'(0));
  endtask

  initial begin
    logic [3:0] exp_en;

    seq_tbl[0]  = '{17, 4'b0000, 4'b0000, 1'b0};
    seq_tbl[1]  = '{18, 4'b0001, 4'b0000, 1'b0};
    seq_tbl[2]  = '{19, 4'b0001, 4'b0001, 1'b0};
    seq_tbl[3]  = '{22, 4'b0011, 4'b0001, 1'b0};
    seq_tbl[4]  = '{23, 4'b0011, 4'b0011, 1'b0};
    seq_tbl[5]  = '{26, 4'b0111, 4'b0011, 1'b0};
    seq_tbl[6]  = '{27, 4'b0111, 4'b0111, 1'b0};
    seq_tbl[7]  = '{30, 4'b1111, 4'b0111, 1'b0};
    seq_tbl[8]  = '{31, 4'b1111, 4'b1111, 1'b0};
    seq_tbl[9]  = '{33, 4'b1111, 4'b1111, 1'b0};
    seq_tbl[10] = '{34, 4'b1111, 4'b1111, 1'b1};

    // Reset state
    #2 rstn_i = 1'b0;
    tick();
    tick();
    $display("reset: rstn_o=%b clk_en_o=%b ready_o=%b lock_lost_o=%b", rstn_o, clk_en_o, ready_o, lock_lost_o);
    check("rst_rstn", 32'(rstn_o), 32'(0));
    check("rst_clk_en", 32'(clk_en_o), 32'(0));
    check("rst_ready", 32'(ready_o), 32'(0));
    check("rst_lock_lost", 32'(lock_lost_o), 32'(0));
    rstn_i = 1'b1;
    tick();
    tick();

    // Power-up release with default ratios
    start_lock();
    run_seq("pwr", 1'b1);

    // Glitchy lock must restart qualification without setting the flag
    do_reset();
    locked_i = 1'b1;
    repeat (10) tick();
    locked_i = 1'b0;
    repeat (3) tick();
    start_lock();
    for (int off = 0; off <= 17; off++) begin
      wait_until(off);
      check("glitch_hold_rstn", 32'(rstn_o), 32'(0));
    end
    check("glitch_lock_lost", 32'(lock_lost_o), 32'(0));
    wait_until(18);
    $display("glitch: t1+%0d rstn_o=%b lock_lost_o=%b", t_now, rstn_o, lock_lost_o);
    check("glitch_release", 32'(rstn_o), 32'(1));

    // Dividers: ch1=3 (updated to 7 mid-period), ch2=5, ch3=0
    do_reset();
    div_i     = {8'd0, 8'd5, 8'd3, 8'd1};
    div_upd_i = 1'b1;
    tick();
    div_upd_i = 1'b0;
    start_lock();
    for (int off = 22; off <= 46; off++) begin
      wait_until(off);
      exp_en[0] = 1'b1;
      exp_en[1] = (off == 25 || off == 28 || off == 31 || off == 38 || off == 45);
      exp_en[2] = (off == 31 || off == 36 || off == 41 || off == 46);
      exp_en[3] = (off >= 31);
      $display("div: t0+%0d clk_en_o=%b", t_now, clk_en_o);
      check("div_clk_en", 32'(clk_en_o), 32'(exp_en));
      if (off == 29) begin
        div_i     = {8'd0, 8'd5, 8'd7, 8'd1};
        div_upd_i = 1'b1;
      end
      if (off == 30) div_upd_i = 1'b0;
    end
    check("div_ready", 32'(ready_o), 32'(1));

    // Lock loss in RUN
    locked_i = 1'b0;
    tick();
    tick();
    check("loss_pre_rstn", 32'(rstn_o), 32'(4'hf));
    check("loss_pre_lock_lost", 32'(lock_lost_o), 32'(0));
    tick();
    $display("loss: rstn_o=%b clk_en_o=%b ready_o=%b lock_lost_o=%b", rstn_o, clk_en_o, ready_o, lock_lost_o);
    check("loss_rstn", 32'(rstn_o), 32'(0));
    check("loss_clk_en", 32'(clk_en_o), 32'(0));
    check("loss_ready", 32'(ready_o), 32'(0));
    check("loss_lock_lost", 32'(lock_lost_o), 32'(1));
    repeat (2) tick();
    lock_lost_clr_i = 1'b1;
    tick();
    lock_lost_clr_i = 1'b0;
    $display("clear: lock_lost_o=%b", lock_lost_o);
    check("clr_lock_lost", 32'(lock_lost_o), 32'(0));

    // Relock repeats the full sequence
    start_lock();
    run_seq("relock", 1'b0);

    // Clear coinciding with a new loss: set wins
    locked_i = 1'b0;
    tick();
    tick();
    lock_lost_clr_i = 1'b1;
    tick();
    lock_lost_clr_i = 1'b0;
    $display("set_vs_clr: rstn_o=%b lock_lost_o=%b", rstn_o, lock_lost_o);
    check("setclr_rstn", 32'(rstn_o), 32'(0));
    check("setclr_lock_lost", 32'(lock_lost_o), 32'(1));
    tick();
    check("setclr_hold", 32'(lock_lost_o), 32'(1));

    // Asynchronous reset during RELEASE with two channels out
    rstn_i   = 1'b0;
    locked_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    tick();
    start_lock();
    wait_until(23);
    check("async_pre_rstn", 32'(rstn_o), 32'(4'b0011));
    #3 rstn_i = 1'b0;
    #1;
    $display("async: rstn_o=%b clk_en_o=%b ready_o=%b lock_lost_o=%b", rstn_o, clk_en_o, ready_o, lock_lost_o);
    check("async_rstn", 32'(rstn_o), 32'(0));
    check("async_clk_en", 32'(clk_en_o), 32'(0));
    check("async_ready", 32'(ready_o), 32'(0));
    check("async_lock_lost", 32'(lock_lost_o), 32'(0));
    tick();
    rstn_i = 1'b1;
    t_now  = -1;
    run_seq("restart", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_rst_seq.md
Name: clk_rst_seq

Overview:
- Parametrised clock-enable and reset sequencer that sits directly behind the board PLL/clock-manager wrapper, in the PLL output clock domain.
- Qualifies the PLL lock indication and releases NUM_CH per-subsystem resets in a staggered order.
- Generates per-channel divided clock-enable strobes whose ratios can be reprogrammed without glitches.
- Lock loss at any time drops every channel back into reset.

Parameters:
- NUM_CH, 4: number of reset/clock-enable channels (1..16).
- DIV_W, 8: width of each channel divide ratio.
- LOCK_CNT, 1024: cycles locked must stay high before the first reset release (>=2).
- STAGGER, 16: cycles between consecutive channel reset releases (>=1).

Ports:
- clk_i, in, 1: PLL output clock; the only clock.
- rstn_i, in, 1: asynchronous active-low reset.
- locked_i, in, 1: PLL lock; asynchronous to clk_i.
- div_i, in, NUM_CH*DIV_W: divide ratios; channel k occupies bits [k*DIV_W +: DIV_W].
- div_upd_i, in, 1: one-cycle pulse that captures div_i into the shadow registers.
- lock_lost_clr_i, in, 1: clears lock_lost_o.
- rstn_o, out, NUM_CH: per-channel active-low reset, registered.
- clk_en_o, out, NUM_CH: per-channel clock-enable strobe, registered.
- ready_o, out, 1: all channels released and running.
- lock_lost_o, out, 1: sticky flag, set when lock drops after release has started.

Behaviour:
- Reset values (rstn_i=0): rstn_o=0, clk_en_o=0, ready_o=0, lock_lost_o=0. FSM=WAIT_LOCK, all counters 0, every shadow divide ratio=1.
- Lock synchroniser: locked_i passes through 2 flops to give locked_s. No other logic samples locked_i.
- FSM states: WAIT_LOCK, STABLE, RELEASE, RUN.
- WAIT_LOCK: stays while locked_s=0. When locked_s=1, go to STABLE with the stable counter cleared.
- STABLE: the counter increments each cycle while locked_s=1. If locked_s=0, return to WAIT_LOCK and clear the counter; no flag is set. When the counter reaches LOCK_CNT-1, go to RELEASE with channel index 0.
- Release timing: let t0 be the first clk_i edge that samples locked_i=1 with locked_i held high from then on.
  - rstn_o[0] rises at edge t0+2+LOCK_CNT.
  - rstn_o[k] rises exactly k*STAGGER cycles after rstn_o[0].
  - Released channels stay at 1.
- RELEASE to RUN: STAGGER cycles after rstn_o[NUM_CH-1] rises, the FSM enters RUN and ready_o rises on that same edge.
- Lock loss in RELEASE or RUN (locked_s=0):
  - On the next edge all rstn_o=0, clk_en_o=0, ready_o=0 and lock_lost_o=1.
  - FSM goes to WAIT_LOCK and the stagger and stable counters are cleared.
  - After lock returns, the full LOCK_CNT qualification and the staggered release repeat.
- lock_lost_o: cleared by lock_lost_clr_i. If a set and a clear occur in the same cycle, the set wins.
- Dividers, one per channel:
  - The divide counter is held at 0 while rstn_o[k]=0.
  - Shadow ratio D<=1: clk_en_o[k]=1 on every cycle while rstn_o[k]=1, starting the cycle after rstn_o[k] rises.
  - D>=2: the counter runs 0..D-1 and wraps. clk_en_o[k] is a 1-cycle pulse when the counter equals D-1.
  - The first pulse comes D cycles after rstn_o[k] rises. Period is exactly D cycles and duty is 1/D.
- Ratio update:
  - div_upd_i captures all of div_i into a pending register and sets a per-channel pending bit.
  - A channel loads its pending value only at its wrap point (counter = D-1, or on any cycle when D<=1) or while it is in reset. No pulse is shortened or duplicated.
  - A second div_upd_i before the load overwrites the pending value.
  - div_upd_i during lock loss or reset-hold is still captured and applies at release.
- Async reset mid-operation: every output returns to its reset value immediately, with no clock needed.
- Out-of-range parameters (LOCK_CNT<2, STAGGER<1, NUM_CH outside 1..16) are a static elaboration error.

Test Plan:
- Power-up, NUM_CH=4, LOCK_CNT=16, STAGGER=4; locked_i=1 sampled at t0 -> rstn_o bits rise at t0+18/22/26/30, ready_o at t0+34, clk_en_o=1111 from t0+31 (all shadow ratios 1).
- Glitchy lock: locked_i high 10 cycles, low 3, high again at t1 -> no rstn_o release before t1+18, lock_lost_o stays 0.
- Divider: channel 2 programmed to 5 before release -> clk_en_o[2] first pulse 5 cycles after rstn_o[2] rises, then every 5 cycles with 1-cycle width; ratio 0 -> constant 1.
- Live update: channel 1 at ratio 3, div_upd_i with ratio 7 mid-period -> current 3-cycle period completes, then 7-cycle period; no pulse lost or doubled.
- Lock loss in RUN: locked_i low -> 3 edges later rstn_o=0000, clk_en_o=0, ready_o=0, lock_lost_o=1. Relock repeats the full sequence. lock_lost_clr_i coinciding with a new loss leaves the flag at 1.
- rstn_i asserted during RELEASE with 2 channels out of reset -> all outputs 0 asynchronously; after deassertion the sequence restarts from WAIT_LOCK.
